// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and bit-mixing functions for the
// SHA-256 single-block compression engine.
//   word_t  - 32-bit word
//   vars_t  - working variables a..h packed as [7:0] words, index 0 = a
//   state_t - engine FSM states
//   K / IV  - round constants and initial hash value
package sha256_pkg;

    typedef logic [31:0]      word_t;
    typedef logic [7:0][31:0] vars_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Packed literal lists element [7] first, so h leads and a trails.
    localparam vars_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic word_t ror(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   i_vars - current a..h (index 0 = a)
//   i_k    - round constant K[t]
//   i_w    - schedule word W[t]
//   o_vars - next a..h
module sha256_round
    import sha256_pkg::*;
(
    input  vars_t i_vars,
    input  word_t i_k,
    input  word_t i_w,
    output vars_t o_vars
);

    word_t w_t1;
    word_t w_t2;

    always_comb begin
        w_t1 = i_vars[7] + bsig1(i_vars[4]) + ch(i_vars[4], i_vars[5], i_vars[6]) + i_k + i_w;
        w_t2 = bsig0(i_vars[0]) + maj(i_vars[0], i_vars[1], i_vars[2]);

        o_vars[0] = w_t1 + w_t2;
        o_vars[1] = i_vars[0];
        o_vars[2] = i_vars[1];
        o_vars[3] = i_vars[2];
        o_vars[4] = i_vars[3] + w_t1;
        o_vars[5] = i_vars[4];
        o_vars[6] = i_vars[5];
        o_vars[7] = i_vars[6];
    end

endmodule

// File: rtl/sha256_block_hasher.sv
// sha256_block_hasher: single-block SHA-256 engine, one round per clock.
//   usr_clk   - clock
//   usr_reset - asynchronous active-high reset
//   i_start   - start request, sampled only when idle
//   i_msg     - pre-padded 512-bit block, word 0 in the MSBs
//   o_valid   - one-cycle strobe, o_hash just updated
//   o_hash    - digest, H0 in the MSBs
module sha256_block_hasher
    import sha256_pkg::*;
#(
    parameter int unsigned BLK_CNT   = 6,
    parameter int unsigned MSG_SIZ   = 512,
    parameter int unsigned MSG_BLK   = 32,
    parameter int unsigned MAX_CNT   = 63,
    parameter int unsigned HASH_SIZE = 256
) (
    input  logic                 usr_clk,
    input  logic                 usr_reset,
    input  logic                 i_start,
    input  logic [MSG_SIZ-1:0]   i_msg,
    output logic                 o_valid,
    output logic [HASH_SIZE-1:0] o_hash
);

    state_t               r_state;
    logic [BLK_CNT-1:0]   r_cnt;
    vars_t                r_vars;
    logic [MSG_BLK-1:0]   r_w [16];
    logic                 r_valid;
    logic [HASH_SIZE-1:0] r_hash;

    vars_t w_next_vars;
    word_t w_w_new;

    sha256_round u_round (
        .i_vars (r_vars),
        .i_k    (K[r_cnt]),
        .i_w    (r_w[0]),
        .o_vars (w_next_vars)
    );

    // Schedule word 16 positions ahead of the one consumed this round.
    assign w_w_new = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];

    always_ff @(posedge usr_clk or posedge usr_reset) begin
        if (usr_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_vars  <= '0;
            r_valid <= 1'b0;
            r_hash  <= '0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= i_msg[MSG_SIZ-1-i*MSG_BLK -: MSG_BLK];
                        end
                        r_vars  <= IV;
                        r_cnt   <= '0;
                        r_state <= StCalc;
                    end
                end
                StCalc: begin
                    r_vars <= w_next_vars;
                    for (int i = 0; i < 15; i++) begin
                        r_w[i] <= r_w[i+1];
                    end
                    r_w[15] <= w_w_new;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == BLK_CNT'(MAX_CNT)) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    for (int i = 0; i < 8; i++) begin
                        r_hash[HASH_SIZE-1-i*MSG_BLK -: MSG_BLK] <= IV[i] + r_vars[i];
                    end
                    r_valid <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_hash  = r_hash;

endmodule

// File: tb/tb_sha256_block_hasher.sv
// Scoreboard bench for sha256_block_hasher: expected digests and their due
// cycle are queued when a block is started and checked when the DUT strobes.
module tb_sha256_block_hasher;

    logic         usr_clk;
    logic         usr_reset;
    logic         i_start;
    logic [511:0] i_msg;
    logic         o_valid;
    logic [255:0] o_hash;

    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    typedef struct {
        logic [255:0] dig;
        int           due;
    } exp_t;

    exp_t         sb [$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] last_hash = '0;
    logic [511:0] msg_abc;
    logic [511:0] msg_empty;

    sha256_block_hasher u_dut (
        .usr_clk   (usr_clk),
        .usr_reset (usr_reset),
        .i_start   (i_start),
        .i_msg     (i_msg),
        .o_valid   (o_valid),
        .o_hash    (o_hash)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    always @(posedge usr_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: capture happens on the next posedge (cyc+1),
    // so the strobe is visible at the negedge after posedge cyc+66.
    task automatic push_exp(input logic [255:0] dig, input int offset);
        exp_t e;
        e.dig = dig;
        e.due = cyc + offset;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge usr_clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 256'(sb.size()), 256'd0);
            sb.delete();
        end
    endtask

    // Monitor: every negedge checks reset values, due strobes, or quiet/held outputs.
    always @(negedge usr_clk) begin
        if (usr_reset) begin
            chk("rst_valid", 256'(o_valid), 256'd0);
            chk("rst_hash", o_hash, 256'd0);
            last_hash = '0;
        end else if (sb.size() != 0 && cyc == sb[0].due) begin
            chk("valid_lat", 256'(o_valid), 256'd1);
            chk("digest", o_hash, sb[0].dig);
            last_hash = sb[0].dig;
            void'(sb.pop_front());
        end else begin
            chk("valid_idle", 256'(o_valid), 256'd0);
            chk("hash_hold", o_hash, last_hash);
        end
    end

    initial begin
        int c;
        msg_abc              = '0;
        msg_abc[511:480]     = 32'h61626380;
        msg_abc[31:0]        = 32'h00000018;
        msg_empty            = '0;
        msg_empty[511:480]   = 32'h80000000;

        usr_reset = 1'b1;
        i_start   = 1'b0;
        i_msg     = '0;
        repeat (5) @(negedge usr_clk);
        usr_reset = 1'b0;

        // "abc" with a one-cycle start pulse
        @(negedge usr_clk);
        i_msg   = msg_abc;
        i_start = 1'b1;
        push_exp(DIG_ABC, 66);
        @(negedge usr_clk);
        i_start = 1'b0;
        i_msg   = {16{32'hdeadbeef}};
        wait_drain(200);

        // empty message
        @(negedge usr_clk);
        i_msg   = msg_empty;
        i_start = 1'b1;
        push_exp(DIG_EMPTY, 66);
        @(negedge usr_clk);
        i_start = 1'b0;
        wait_drain(200);

        // start held high: three back-to-back hashes, 66 cycles apart
        @(negedge usr_clk);
        c       = cyc;
        i_msg   = msg_abc;
        i_start = 1'b1;
        push_exp(DIG_ABC, 66);
        push_exp(DIG_ABC, 132);
        push_exp(DIG_ABC, 198);
        while (cyc < c + 133) @(negedge usr_clk);
        i_start = 1'b0;
        wait_drain(300);

        // disturb i_msg / i_start while busy, including on the completion edge
        @(negedge usr_clk);
        c       = cyc;
        i_msg   = msg_abc;
        i_start = 1'b1;
        push_exp(DIG_ABC, 66);
        @(negedge usr_clk);
        i_start = 1'b0;
        repeat (18) @(negedge usr_clk);
        i_msg   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom};
        i_start = 1'b1;
        @(negedge usr_clk);
        i_start = 1'b0;
        while (cyc < c + 65) @(negedge usr_clk);
        i_start = 1'b1;
        @(negedge usr_clk);
        i_start = 1'b0;
        wait_drain(200);
        repeat (10) @(negedge usr_clk);

        // abort at round 30 with an asynchronous mid-cycle reset
        @(negedge usr_clk);
        c       = cyc;
        i_msg   = msg_abc;
        i_start = 1'b1;
        @(negedge usr_clk);
        i_start = 1'b0;
        while (cyc < c + 31) @(negedge usr_clk);
        @(posedge usr_clk);
        #2;
        usr_reset = 1'b1;
        #1;
        chk("async_rst_valid", 256'(o_valid), 256'd0);
        chk("async_rst_hash", o_hash, 256'd0);
        last_hash = '0;
        repeat (3) @(negedge usr_clk);
        usr_reset = 1'b0;
        @(negedge usr_clk);
        i_msg   = msg_empty;
        i_start = 1'b1;
        push_exp(DIG_EMPTY, 66);
        @(negedge usr_clk);
        i_start = 1'b0;
        wait_drain(200);
        repeat (70) @(negedge usr_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
